// File: rtl/multdiv_seq_pkg.sv
// Shared types and constants for the sequential multiply/divide unit.
package multdiv_seq_pkg;

    localparam int WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Iteration counter must hold 0..ITER-1 with a spare bit of headroom.
    function automatic int cnt_width(input int iter);
        return $clog2(iter) + 1;
    endfunction

endpackage

// File: rtl/md_addsub.sv
// WIDTH+1 bit adder/subtractor shared by the iteration datapath and the sign fix.
module md_addsub #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0] a,
    input  logic [WIDTH:0] b,
    input  logic           sub,
    output logic [WIDTH:0] sum
);

    logic [WIDTH:0] b_eff_s;

    // Subtraction is a + ~b + 1, the same invert-plus-one negation used by the ALU.
    assign b_eff_s = b ^ {(WIDTH+1){sub}};
    assign sum     = a + b_eff_s + {{WIDTH{1'b0}}, sub};

endmodule

// File: rtl/multdiv_seq.sv
// Multicycle signed multiply/divide: one bit per clock on magnitudes, then a sign/exception fix cycle.
module multdiv_seq
    import multdiv_seq_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int ITER  = WIDTH
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam int CNT_W = cnt_width(ITER);

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        if (v[WIDTH-1]) begin
            return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            return v;
        end
    endfunction

    state_t           state_r, state_n_s;
    logic [CNT_W-1:0] cnt_r;
    logic             is_mult_r, sign_a_r, sign_b_r;
    logic [WIDTH-1:0] opnd_r, hi_r, lo_r;
    logic [WIDTH-1:0] hi_n_s, lo_n_s;
    logic [WIDTH:0]   add_a_s, add_b_s, add_sum_s, shifted_s, mul_sel_s;
    logic             add_sub_s;
    logic             start_s, last_iter_s, neg_s, mul_ovf_s, div_zero_s, div_ovf_s;
    logic [WIDTH-1:0] fix_res_s;
    logic             fix_exc_s;
    logic [WIDTH-1:0] result_r;
    logic             exc_r, rdy_r, busy_r;

    assign start_s     = ctrl_MULT | ctrl_DIV;
    assign last_iter_s = (cnt_r == CNT_W'(ITER - 1));
    assign shifted_s   = {hi_r, lo_r[WIDTH-1]};
    assign mul_sel_s   = lo_r[0] ? add_sum_s : {1'b0, hi_r};

    md_addsub #(.WIDTH(WIDTH)) u_addsub (
        .a   (add_a_s),
        .b   (add_b_s),
        .sub (add_sub_s),
        .sum (add_sum_s)
    );

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_n_s;
        end
    end

    // Next-state logic; a start pulse restarts from any state.
    always_comb begin
        state_n_s = state_r;
        if (start_s) begin
            state_n_s = RUN;
        end else begin
            case (state_r)
                IDLE:    state_n_s = IDLE;
                RUN:     state_n_s = last_iter_s ? FIX : RUN;
                FIX:     state_n_s = DONE;
                DONE:    state_n_s = IDLE;
                default: state_n_s = IDLE;
            endcase
        end
    end

    // Shared adder operand select: negate in FIX, shift-add or trial-subtract in RUN.
    always_comb begin
        add_a_s   = {(WIDTH+1){1'b0}};
        add_b_s   = {1'b0, opnd_r};
        add_sub_s = 1'b0;
        if (state_r == FIX) begin
            add_b_s   = {1'b0, lo_r};
            add_sub_s = 1'b1;
        end else if (is_mult_r) begin
            add_a_s   = {1'b0, hi_r};
        end else begin
            add_a_s   = shifted_s;
            add_sub_s = 1'b1;
        end
    end

    // Iteration next values; the quotient and low product both end up in lo_r.
    always_comb begin
        hi_n_s = hi_r;
        lo_n_s = lo_r;
        if (is_mult_r) begin
            hi_n_s = mul_sel_s[WIDTH:1];
            lo_n_s = {mul_sel_s[0], lo_r[WIDTH-1:1]};
        end else if (!add_sum_s[WIDTH]) begin
            hi_n_s = add_sum_s[WIDTH-1:0];
            lo_n_s = {lo_r[WIDTH-2:0], 1'b1};
        end else begin
            hi_n_s = shifted_s[WIDTH-1:0];
            lo_n_s = {lo_r[WIDTH-2:0], 1'b0};
        end
    end

    // Sign fix and exceptions, judged on the unsigned magnitude result.
    always_comb begin
        neg_s      = sign_a_r ^ sign_b_r;
        div_zero_s = (opnd_r == {WIDTH{1'b0}});
        div_ovf_s  = !neg_s && lo_r[WIDTH-1];
        fix_res_s  = neg_s ? add_sum_s[WIDTH-1:0] : lo_r;
        fix_exc_s  = 1'b0;
        // A negative product may reach exactly 2^(WIDTH-1); a positive one may not.
        if (neg_s) begin
            mul_ovf_s = (|hi_r) || (lo_r[WIDTH-1] && (|lo_r[WIDTH-2:0]));
        end else begin
            mul_ovf_s = (|hi_r) || lo_r[WIDTH-1];
        end
        if (is_mult_r) begin
            fix_exc_s = mul_ovf_s;
        end else if (div_zero_s) begin
            fix_res_s = {WIDTH{1'b0}};
            fix_exc_s = 1'b1;
        end else begin
            fix_exc_s = div_ovf_s;
        end
    end

    // Operand capture, iteration and output load.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r     <= {CNT_W{1'b0}};
            is_mult_r <= 1'b0;
            sign_a_r  <= 1'b0;
            sign_b_r  <= 1'b0;
            opnd_r    <= {WIDTH{1'b0}};
            hi_r      <= {WIDTH{1'b0}};
            lo_r      <= {WIDTH{1'b0}};
            result_r  <= {WIDTH{1'b0}};
            exc_r     <= 1'b0;
        end else if (start_s) begin
            cnt_r     <= {CNT_W{1'b0}};
            is_mult_r <= ctrl_MULT;
            sign_a_r  <= data_operandA[WIDTH-1];
            sign_b_r  <= data_operandB[WIDTH-1];
            opnd_r    <= ctrl_MULT ? magnitude(data_operandA) : magnitude(data_operandB);
            lo_r      <= ctrl_MULT ? magnitude(data_operandB) : magnitude(data_operandA);
            hi_r      <= {WIDTH{1'b0}};
        end else begin
            case (state_r)
                RUN: begin
                    cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    hi_r  <= hi_n_s;
                    lo_r  <= lo_n_s;
                end
                FIX: begin
                    result_r <= fix_res_s;
                    exc_r    <= fix_exc_s;
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    // Handshake outputs; an operation abandoned by a restart never strobes.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rdy_r  <= 1'b0;
            busy_r <= 1'b0;
        end else begin
            rdy_r  <= (state_r == DONE) && !start_s;
            busy_r <= (state_n_s == RUN) || (state_n_s == FIX);
        end
    end

    assign data_result    = result_r;
    assign data_exception = exc_r;
    assign data_resultRDY = rdy_r;
    assign busy           = busy_r;

endmodule

// File: tb/tb_multdiv_seq.sv
// Scoreboard bench for multdiv_seq: directed operations, expected results queued at issue time.
module tb_multdiv_seq;

    localparam int LAT = 34;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] data_operandA = 32'd0;
    logic [31:0] data_operandB = 32'd0;
    logic        ctrl_MULT = 1'b0;
    logic        ctrl_DIV = 1'b0;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    typedef struct {
        logic [31:0] res;
        logic        exc;
        int          due;
    } exp_t;

    exp_t sb_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    multdiv_seq #(.WIDTH(32), .ITER(32)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Monitor: every strobe must match the oldest outstanding expectation.
    always @(negedge clock) begin : monitor
        exp_t e;
        if (data_resultRDY !== 1'b0) begin
            if (sb_q.size() == 0) begin
                check("unexpected_rdy", {31'd0, data_resultRDY}, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("result", data_result, e.res);
                check("exception", {31'd0, data_exception}, {31'd0, e.exc});
                check("latency", cyc, e.due);
                check("busy_in_rdy", {31'd0, busy}, 32'd0);
            end
        end
    end

    // Issue a start pulse; a restart abandons whatever was outstanding.
    task automatic start_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] res, input logic exc);
        exp_t e;
        @(posedge clock);
        #2;
        sb_q.delete();
        ctrl_MULT     = m;
        ctrl_DIV      = d;
        data_operandA = a;
        data_operandB = b;
        e.res = res;
        e.exc = exc;
        e.due = cyc + 1 + LAT;
        sb_q.push_back(e);
        @(posedge clock);
        #1;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = 32'hDEAD_BEEF;
        data_operandB = 32'h1234_5678;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 60 && sb_q.size() != 0; i++) @(negedge clock);
        if (sb_q.size() != 0) begin
            check("timeout_pending", sb_q.size(), 32'd0);
            sb_q.delete();
        end
        repeat (3) @(negedge clock);
    endtask

    initial begin
        #12;
        check("reset_result", data_result, 32'd0);
        check("reset_exc", {31'd0, data_exception}, 32'd0);
        check("reset_rdy", {31'd0, data_resultRDY}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;

        start_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);
        @(negedge clock);
        check("busy_run", {31'd0, busy}, 32'd1);
        wait_done();

        start_op(1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1);
        wait_done();
        start_op(1'b1, 1'b0, 32'h8000_0000, 32'd1, 32'h8000_0000, 1'b0);
        wait_done();
        start_op(1'b1, 1'b0, 32'hFFFF_FFFB, 32'hFFFF_FFFB, 32'd25, 1'b0);
        wait_done();

        start_op(1'b0, 1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 1'b0);
        wait_done();
        start_op(1'b0, 1'b1, 32'd100, 32'd0, 32'd0, 1'b1);
        wait_done();
        start_op(1'b0, 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0);
        wait_done();
        start_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
        wait_done();
        start_op(1'b1, 1'b1, 32'd6, 32'd3, 32'd18, 1'b0);
        wait_done();

        // Restart: DIV lands 10 edges after the MULT start; only the DIV completes.
        start_op(1'b1, 1'b0, 32'd3, 32'd4, 32'd12, 1'b0);
        repeat (8) @(posedge clock);
        #1;
        check("hold_prior", data_result, 32'd18);
        start_op(1'b0, 1'b1, 32'd20, 32'd5, 32'd4, 1'b0);
        wait_done();

        // Asynchronous reset between edges mid-RUN.
        start_op(1'b1, 1'b0, 32'd9, 32'd9, 32'd81, 1'b0);
        repeat (5) @(posedge clock);
        #3;
        reset_n = 1'b0;
        #1;
        sb_q.delete();
        check("async_rst_result", data_result, 32'd0);
        check("async_rst_exc", {31'd0, data_exception}, 32'd0);
        check("async_rst_busy", {31'd0, busy}, 32'd0);
        check("async_rst_rdy", {31'd0, data_resultRDY}, 32'd0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (40) @(negedge clock);
        start_op(1'b1, 1'b0, 32'd2, 32'd5, 32'd10, 1'b0);
        wait_done();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multdiv_seq.md
Name: multdiv_seq

Overview:
- Multicycle signed multiply/divide unit; the sequential companion to the single-cycle ALU in the processor execute stage.
- Accepts a one-cycle start pulse (ctrl_MULT or ctrl_DIV) and iterates one bit per clock.
- Raises data_resultRDY for exactly one cycle when data_result and data_exception are valid.
- Pipeline stalls on busy and releases on data_resultRDY.

Parameters:
WIDTH, 32, operand/result width in bits.
ITER, WIDTH, number of iteration cycles; must equal WIDTH.

Ports:
clock  input  1  single clock; all state updates on rising edge.
reset_n  input  1  asynchronous, active-low reset.
data_operandA  input  WIDTH  multiplicand / dividend; sampled only on the start edge.
data_operandB  input  WIDTH  multiplier / divisor; sampled only on the start edge.
ctrl_MULT  input  1  start-multiply pulse.
ctrl_DIV  input  1  start-divide pulse.
data_result  output  WIDTH  low WIDTH bits of product, or quotient.
data_exception  output  1  overflow or divide-by-zero flag, valid with result.
data_resultRDY  output  1  one-cycle completion strobe.
busy  output  1  high while an operation is in flight.

Behaviour:
- Reset (reset_n low, async):
  - state=IDLE, counter=0, all internal registers 0.
  - data_result=0, data_exception=0, data_resultRDY=0, busy=0.
  - Takes effect immediately, including mid-operation; no completion strobe is produced for an aborted operation.
- States: IDLE -> RUN -> FIX -> DONE -> IDLE.
- Start edge (any state, including RUN/FIX/DONE):
  - If ctrl_MULT=1, start a multiply. ctrl_MULT has priority if both are high; ctrl_DIV is then ignored.
  - Else if ctrl_DIV=1, start a divide.
  - Latch operands, record signs and the op, capture magnitudes, clear counter.
  - Go to RUN; busy=1.
  - Any in-flight operation is abandoned silently (restart semantics).
- RUN: one iteration per edge, counter 0..ITER-1; after the ITER-th iteration go to FIX.
  - Multiply: unsigned shift-add on magnitudes into a 2*WIDTH accumulator.
  - Divide: restoring division on magnitudes; a WIDTH+1 bit partial remainder is shifted left, then trial-subtracted by the divisor magnitude. The quotient bit is 1 if the result is nonnegative, else the remainder is restored.
- FIX (1 cycle): apply sign and exceptions; load output registers; go to DONE.
  - Result is negated if the signs differ.
  - Quotient truncates toward zero; the remainder is discarded.
  - Multiply exception: set if the signed 2*WIDTH product does not fit in WIDTH bits, i.e. the upper WIDTH+1 bits are not all equal. data_result is still the low WIDTH bits.
  - Divide by zero: data_result=0, data_exception=1. Full latency is still taken.
  - Divide overflow: 0x80000000 / 0xFFFFFFFF gives data_result=0x80000000, data_exception=1.
- DONE: data_resultRDY=1 for this cycle only, busy=0, go to IDLE.
- Latency: if the start is sampled at edge E, data_resultRDY is high in the cycle after edge E+ITER+2 (E+34 for WIDTH=32). Latency is fixed for every operand pair.
- data_result and data_exception:
  - Hold their last value through IDLE.
  - Remain unchanged during RUN of the next operation.
  - Update only on the FIX->DONE edge.
- Arithmetic: all iteration adds/subtracts go through one shared WIDTH+1 bit adder/subtractor. Two's-complement negation is invert + 1 on the same adder style as the ALU.

Decomposition:
- Shared package:
  - State encoding constants IDLE=2'd0, RUN=2'd1, FIX=2'd2, DONE=2'd3.
  - WIDTH default.
  - Counter width = clog2(ITER)+1.
- One natural sub-module: md_addsub, a WIDTH+1 bit add/subtract unit built on the existing cla_32_bit with a sign-extension bit. It is instantiated once in multdiv_seq and reused for both iteration and sign fix.

Test Plan:
1. MULT A=7, B=0xFFFFFFFD (-3) -> data_resultRDY high exactly 34 edges after start; data_result=0xFFFFFFEB, data_exception=0, busy low in the RDY cycle.
2. MULT A=0x00010000, B=0x00010000 -> data_result=0x00000000, data_exception=1; MULT 0x80000000 * 1 -> 0x80000000, exception 0.
3. DIV A=0xFFFFFF9C (-100), B=7 -> data_result=0xFFFFFFF2 (-14), exception 0. DIV 100/0 -> result 0, exception 1, still 34-edge latency.
4. DIV A=0x80000000, B=0xFFFFFFFF -> result 0x80000000, exception 1. ctrl_MULT and ctrl_DIV high together with A=6, B=3 -> result 18 (multiply taken).
5. MULT 3*4 started, then DIV 20/5 pulsed 10 edges later -> exactly one RDY, 34 edges after the DIV start, result 4. No RDY for the multiply; data_result holds its prior value until then.
6. reset_n driven low asynchronously mid-RUN (between edges) -> outputs 0 immediately, no RDY. After release, MULT 2*5 -> result 10 at 34 edges.
